// File: rtl/pipeline_fifo_ctrl.sv
// Pipeline FIFO with valid/ready ports; same-cycle order deq < enq < clear.
// Define PIPELINE_FIFO_BYPASS_EN for a same-cycle pass-through when empty.
module pipeline_fifo_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_data,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_data,
   input  logic             clear,
   output logic [AW:0]      count
);

   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             empty, full, byp;
   logic             deq_fire, enq_fire;
   logic             wr_en, rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

`ifdef PIPELINE_FIFO_BYPASS_EN
   assign byp = empty & enq_valid & ~clear;
`else
   assign byp = 1'b0;
`endif

   assign deq_valid = ~empty | byp;
   assign deq_data  = byp ? enq_data : mem_q[rd_ptr_q];
   assign deq_fire  = deq_valid & deq_ready;
   assign enq_ready = ~full | deq_fire;
   assign enq_fire  = enq_valid & enq_ready;
   assign count     = count_q;

   // A bypassed item leaves in the cycle it arrives; storage is untouched.
   assign wr_en = enq_fire & ~(byp & deq_ready) & ~clear;
   assign rd_en = deq_fire & ~byp & ~clear;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + AW'(rd_en);
         wr_ptr_d = wr_ptr_q + AW'(wr_en);
         count_d  = count_q + CW'(wr_en) - CW'(rd_en);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= enq_data;
   end

endmodule

// File: tb/tb_pipeline_fifo_ctrl.sv
// Self-checking bench for pipeline_fifo_ctrl against a queue-based model.
// Honours PIPELINE_FIFO_BYPASS_EN when the DUT is built with it.
module tb_pipeline_fifo_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

`ifdef PIPELINE_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enq_valid = 1'b0;
   logic             enq_ready;
   logic [WIDTH-1:0] enq_data = '0;
   logic             deq_valid;
   logic             deq_ready = 1'b0;
   logic [WIDTH-1:0] deq_data;
   logic             clear = 1'b0;
   logic [AW:0]      count;

   int n_chk = 0;
   int n_fail = 0;
   logic [WIDTH-1:0] q[$];

   pipeline_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
      .clear(clear), .count(count)
   );

   always #5 clk = ~clk;

   function automatic bit m_byp();
      return BYP && q.size() == 0 && enq_valid && !clear;
   endfunction

   function automatic bit m_dv();
      return q.size() != 0 || m_byp();
   endfunction

   function automatic logic [WIDTH-1:0] m_dd();
      if (m_byp()) return enq_data;
      if (q.size() != 0) return q[0];
      return '0;
   endfunction

   function automatic bit m_er();
      return q.size() != DEPTH || (m_dv() && deq_ready);
   endfunction

   // Advance one clock and apply the same-cycle rules to the model.
   task automatic tick();
      bit df, ef, pass;
      df   = m_dv() && deq_ready;
      ef   = enq_valid && m_er();
      pass = m_byp() && deq_ready;
      @(posedge clk);
      if (clear) q.delete();
      else if (!pass) begin
         if (df) void'(q.pop_front());
         if (ef) q.push_back(enq_data);
      end
      @(negedge clk);
   endtask

   task automatic drive(bit ev, logic [7:0] d, bit dr, bit clr);
      enq_valid = ev;
      enq_data  = d;
      deq_ready = dr;
      clear     = clr;
      #1;
   endtask

   task automatic test_reset();
      drive(0, 8'h00, 0, 0);
      #5;
      n_chk++;
      if (count !== 3'd0) begin
         n_fail++; $display("FAIL reset_count got %0d exp 0", count);
      end
      n_chk++;
      if (deq_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_deq_valid got %0b exp 0", deq_valid);
      end
      n_chk++;
      if (enq_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_enq_ready got %0b exp 1", enq_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill_drain();
      logic [7:0] pat [4];
      pat = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         drive(1, pat[i], 0, 0);
         tick();
      end
      drive(1, 8'h99, 0, 0);
      n_chk++;
      if (count !== 3'd4) begin
         n_fail++; $display("FAIL fill_count got %0d exp 4", count);
      end
      n_chk++;
      if (enq_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_enq_ready got %0b exp 0", enq_ready);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h00, 1, 0);
         n_chk++;
         if (deq_valid !== 1'b1 || deq_data !== pat[i]) begin
            n_fail++;
            $display("FAIL drain_%0d got v=%0b d=%0h exp v=1 d=%0h",
                     i, deq_valid, deq_data, pat[i]);
         end
         tick();
      end
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (count !== 3'd0 || deq_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty got c=%0d v=%0b exp c=0 v=0", count, deq_valid);
      end
   endtask

   task automatic test_full_both();
      logic [7:0] exp [4];
      exp = '{8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 1; i <= 4; i++) begin
         drive(1, 8'(i * 8'h11), 0, 0);
         tick();
      end
      drive(1, 8'h55, 1, 0);
      n_chk++;
      if (enq_ready !== 1'b1 || deq_data !== 8'h11) begin
         n_fail++;
         $display("FAIL full_both got rdy=%0b d=%0h exp rdy=1 d=11", enq_ready, deq_data);
      end
      tick();
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (count !== 3'd4) begin
         n_fail++; $display("FAIL full_both_count got %0d exp 4", count);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h00, 1, 0);
         n_chk++;
         if (deq_data !== exp[i]) begin
            n_fail++;
            $display("FAIL full_both_pop_%0d got %0h exp %0h", i, deq_data, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_stream();
      int nxt = 0;
      for (int i = 0; i < 11; i++) begin
         drive(i < 10, 8'(i), 1, 0);
         if (i < 10) begin
            n_chk++;
            if (enq_ready !== 1'b1) begin
               n_fail++; $display("FAIL stream_stall_%0d got %0b exp 1", i, enq_ready);
            end
         end
         if (deq_valid === 1'b1) begin
            n_chk++;
            if (deq_data !== 8'(nxt)) begin
               n_fail++; $display("FAIL stream_order got %0h exp %0h", deq_data, nxt);
            end
            nxt++;
         end
         tick();
      end
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (nxt != 10 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL stream_total got n=%0d c=%0d exp n=10 c=0", nxt, count);
      end
   endtask

   task automatic test_clear();
      drive(1, 8'h01, 0, 0); tick();
      drive(1, 8'h02, 0, 0); tick();
      drive(1, 8'h66, 1, 1); tick();
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (count !== 3'd0 || deq_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clear got c=%0d v=%0b exp c=0 v=0", count, deq_valid);
      end
      drive(1, 8'h88, 0, 0); tick();
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (count !== 3'd1 || deq_data !== 8'h88) begin
         n_fail++;
         $display("FAIL clear_after got c=%0d d=%0h exp c=1 d=88", count, deq_data);
      end
      drive(0, 8'h00, 1, 0); tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'(8'hA0 + i), 0, 0);
         tick();
      end
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (count !== 3'd3) begin
         n_fail++; $display("FAIL areset_pre got %0d exp 3", count);
      end
      #1 rst_n = 1'b0;
      #1;
      q.delete();
      n_chk++;
      if (count !== 3'd0 || deq_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset got c=%0d v=%0b exp c=0 v=0", count, deq_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bypass();
      drive(1, 8'h77, 1, 0);
`ifdef PIPELINE_FIFO_BYPASS_EN
      n_chk++;
      if (deq_valid !== 1'b1 || deq_data !== 8'h77) begin
         n_fail++;
         $display("FAIL bypass got v=%0b d=%0h exp v=1 d=77", deq_valid, deq_data);
      end
      tick();
      drive(0, 8'h00, 0, 0);
      n_chk++;
      if (count !== 3'd0) begin
         n_fail++; $display("FAIL bypass_count got %0d exp 0", count);
      end
`else
      n_chk++;
      if (deq_valid !== 1'b0) begin
         n_fail++; $display("FAIL nobypass got v=%0b exp 0", deq_valid);
      end
      tick();
      drive(0, 8'h00, 1, 0);
      n_chk++;
      if (deq_valid !== 1'b1 || deq_data !== 8'h77) begin
         n_fail++;
         $display("FAIL nobypass_next got v=%0b d=%0h exp v=1 d=77", deq_valid, deq_data);
      end
      tick();
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom),
               $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
         n_chk++;
         if (enq_ready !== m_er() || deq_valid !== m_dv() ||
             count !== 3'(q.size())) begin
            n_fail++;
            $display("FAIL rand_ctl_%0d got r=%0b v=%0b c=%0d exp r=%0b v=%0b c=%0d",
                     i, enq_ready, deq_valid, count, m_er(), m_dv(), q.size());
         end
         if (m_dv()) begin
            n_chk++;
            if (deq_data !== m_dd()) begin
               n_fail++;
               $display("FAIL rand_data_%0d got %0h exp %0h", i, deq_data, m_dd());
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_both();
      test_stream();
      test_clear();
      test_async_reset();
      test_bypass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
